bullet_pool_drawer: RTL and testbench
=====================================

Name: bullet_pool_drawer

Overview:
Multi-bullet sprite engine for the duck-hunt VGA pipeline. Holds up to NUM_BULLETS independent bullets. Spawns each through a valid/ready fire handshake, moves each bullet up SPEED pixels per frame, and retires it when it is fully off the top of the screen or when it is killed externally. Produces a registered 6-bit pixel colour and draw flag for the pixel mux, alongside the other sprite drawers.

Parameters:
NUM_BULLETS, 4, number of bullet slots (1..8)
BULLET_W, 8, bullet width in pixels
BULLET_H, 11, bullet height in pixels
SPEED, 4, upward move per frame_tick in pixels (1..31)
COLOR, 6'b101010, bullet pixel colour
COLOR_ALT, 6'b111111, alternate colour (optional feature only)

Ports:
clk  in  1  pixel clock
reset  in  1  synchronous, active-low reset
hcount  in  10  current pixel column
vcount  in  10  current pixel row
frame_tick  in  1  one-cycle pulse once per frame, during vertical blanking
fire_valid  in  1  spawn request
fire_ready  out  1  a free slot exists
fire_x  in  10  spawn column (left edge)
fire_y  in  10  spawn row (top edge), signed
kill_mask  in  NUM_BULLETS  per-slot retire strobe, for example on a duck hit
active_mask  out  NUM_BULLETS  slot i holds a live bullet
data  out  6  pixel colour
draw  out  1  a bullet covers the current pixel

Behaviour:
- Per-slot state: active (1 bit), x (10-bit unsigned), y (10-bit signed).
- Reset (reset==0 at a clk edge): all active bits cleared; x and y cleared to 0; data=0, draw=0, fire_ready=0 in the cycle after reset. Reset has priority over every other input, mid-flight included.
- fire_ready: combinational, equal to OR of ~active_mask. It does not depend on fire_valid.
- Fire accept: fire_valid && fire_ready at an edge.
  - The lowest-index inactive slot loads x=fire_x, y=fire_y, active=1.
  - active_mask shows the new slot the next cycle.
  - fire_valid while fire_ready==0 is ignored; it is not queued.
- Move on frame_tick: every active slot not being spawned or killed in the same cycle updates y <= y - SPEED.
  - The subtraction is 11-bit signed.
  - If (y - SPEED) + BULLET_H <= 0, the slot clears active; y is don't-care.
- Kill: kill_mask[i]==1 clears active[i] the next cycle.
  - Kill beats move.
  - Kill on an inactive slot has no effect.
- Simultaneous events:
  - Fire allocation uses the pre-edge active mask. A slot being killed in that cycle is not eligible, so there are no slot conflicts.
  - A slot spawned on a frame_tick cycle loads fire_y unmoved.
  - A slot that retires or is killed becomes eligible to spawn the following cycle.
- Pixel path, 1-cycle latency: data and draw are registered from that cycle's hcount, vcount and slot state.
  - Slot i hits when active[i], $signed({1'b0,vcount}) >= y, $signed({1'b0,vcount}) <= y+BULLET_H-1, hcount >= x and hcount < x+BULLET_W.
  - Compare in 11-bit signed / 11-bit unsigned so that x+BULLET_W near 1023 does not wrap.
  - draw = OR of all hits; data = COLOR when draw, else 6'b000000.
  - Overlapping bullets produce the same colour, so no priority is needed.
- Bullets partially above row 0 (negative y) still draw their visible rows.
- No register wraps. y only decreases until retire, and valid spawns are in the range 0..479.

Optional Feature:
Macro BULLET_COLOR_CYCLE_EN.
- Defined: a 1-bit phase register toggles on every frame_tick and is cleared by reset. data = COLOR when phase==0 and COLOR_ALT when phase==1, whenever draw==1.
- Undefined: no phase register; data is always COLOR when drawing. Behaviour is otherwise identical.

Test Plan:
1. Reset, then fire_valid=1 with fire_x=100, fire_y=400 for one cycle -> fire_ready=1 before the edge; the next cycle active_mask=4'b0001. With hcount=100..107 and vcount=400..410, draw=1 and data=6'b101010 one cycle later. hcount=108 or vcount=411 gives draw=0.
2. Hold fire_valid=1 for 5 cycles with no frame_tick -> slots 0..3 fill in order; fire_ready=0 after the 4th accept; the 5th request is ignored and active_mask stays 4'b1111.
3. Spawn at y=10, then pulse frame_tick 5 times -> y=6, 2, -2, -6. The 5th tick gives -10+11=1>0, so the slot stays active with only row 0 visible (vcount=0 draws). The 6th tick gives -14 and active clears.
4. Four bullets active; kill_mask=4'b0100 together with frame_tick and fire_valid in the same cycle -> slot 2 cleared, slots 0/1/3 moved by 4, fire ignored (fire_ready=0). The next cycle fire_valid is accepted into slot 2.
5. Reset asserted (0) mid-flight while frame_tick=1 and fire_valid=1 -> the following cycle active_mask=0, draw=0, data=0, and no slot is loaded.
6. With BULLET_COLOR_CYCLE_EN: a drawn pixel gives data=6'b101010; after one frame_tick, the same pixel on the moved bullet gives 6'b111111.

Source files
------------

// File: rtl/bullet_pool_drawer.sv
// bullet_pool_drawer: pool of bullet sprites with fire handshake, per-frame upward motion and registered pixel output.
// Optional BULLET_COLOR_CYCLE_EN alternates COLOR/COLOR_ALT on every frame_tick.
module bullet_pool_drawer #(
    parameter int         NUM_BULLETS = 4,
    parameter int         BULLET_W    = 8,
    parameter int         BULLET_H    = 11,
    parameter int         SPEED       = 4,
    parameter logic [5:0] COLOR       = 6'b101010
`ifdef BULLET_COLOR_CYCLE_EN
    , parameter logic [5:0] COLOR_ALT = 6'b111111
`endif
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic [9:0]             i_hcount,
    input  logic [9:0]             i_vcount,
    input  logic                   i_frame_tick,
    input  logic                   i_fire_valid,
    output logic                   o_fire_ready,
    input  logic [9:0]             i_fire_x,
    input  logic [9:0]             i_fire_y,
    input  logic [NUM_BULLETS-1:0] i_kill_mask,
    output logic [NUM_BULLETS-1:0] o_active_mask,
    output logic [5:0]             o_data,
    output logic                   o_draw
);
    localparam logic signed [10:0] L_H     = 11'(BULLET_H);
    localparam logic signed [10:0] L_SPEED = 11'(SPEED);
    localparam logic [10:0]        L_W     = 11'(BULLET_W);

    logic [NUM_BULLETS-1:0] r_active;
    logic [9:0]             r_x [NUM_BULLETS];
    logic signed [9:0]      r_y [NUM_BULLETS];
    logic                   r_en;
    logic [5:0]             r_data;
    logic                   r_draw;

    logic [NUM_BULLETS-1:0] w_free, w_spawn, w_hit, w_retire;
    logic signed [10:0]     w_ys [NUM_BULLETS];
    logic signed [10:0]     w_ny [NUM_BULLETS];
    logic signed [10:0]     w_v;
    logic [10:0]            w_h;
    logic [5:0]             w_color;

    assign w_free        = ~r_active;
    // r_en holds fire_ready low for the first cycle out of reset
    assign o_fire_ready  = r_en & (|w_free);
    assign w_spawn       = (i_fire_valid && o_fire_ready) ? (w_free & (r_active + NUM_BULLETS'(1))) : '0;
    assign w_v           = $signed({1'b0, i_vcount});
    assign w_h           = {1'b0, i_hcount};
    assign o_active_mask = r_active;
    assign o_data        = r_data;
    assign o_draw        = r_draw;

    always_comb begin
        for (int i = 0; i < NUM_BULLETS; i++) begin
            w_ys[i]     = {r_y[i][9], r_y[i]};
            w_ny[i]     = w_ys[i] - L_SPEED;
            w_retire[i] = (w_ny[i] + L_H) <= 11'sd0;
            w_hit[i]    = r_active[i] && (w_v >= w_ys[i]) && (w_v <= w_ys[i] + L_H - 11'sd1)
                          && (w_h >= {1'b0, r_x[i]}) && (w_h < {1'b0, r_x[i]} + L_W);
        end
    end

`ifdef BULLET_COLOR_CYCLE_EN
    logic r_phase;
    assign w_color = r_phase ? COLOR_ALT : COLOR;
    always_ff @(posedge i_clk) begin
        if (!i_reset)
            r_phase <= 1'b0;
        else if (i_frame_tick)
            r_phase <= ~r_phase;
    end
`else
    assign w_color = COLOR;
`endif

    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_active <= '0;
            r_en     <= 1'b0;
            r_data   <= 6'b0;
            r_draw   <= 1'b0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                r_x[i] <= '0;
                r_y[i] <= '0;
            end
        end else begin
            r_en   <= 1'b1;
            r_draw <= |w_hit;
            r_data <= (|w_hit) ? w_color : 6'b0;
            for (int i = 0; i < NUM_BULLETS; i++) begin
                if (w_spawn[i]) begin
                    r_active[i] <= 1'b1;
                    r_x[i]      <= i_fire_x;
                    r_y[i]      <= i_fire_y;
                end else if (i_kill_mask[i]) begin
                    r_active[i] <= 1'b0;
                end else if (i_frame_tick && r_active[i]) begin
                    r_y[i]      <= w_ny[i][9:0];
                    r_active[i] <= ~w_retire[i];
                end
            end
        end
    end
endmodule

// File: tb/tb_bullet_pool_drawer.sv
// tb_bullet_pool_drawer: directed checks of fire, motion, kill, pixel hits and reset for bullet_pool_drawer.
module tb_bullet_pool_drawer;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [9:0] hcount = '0, vcount = '0;
    logic       frame_tick = 1'b0, fire_valid = 1'b0;
    logic       fire_ready;
    logic [9:0] fire_x = '0, fire_y = '0;
    logic [3:0] kill_mask = '0;
    logic [3:0] active_mask;
    logic [5:0] data;
    logic       draw;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    bullet_pool_drawer dut (
        .i_clk(clk), .i_reset(reset), .i_hcount(hcount), .i_vcount(vcount),
        .i_frame_tick(frame_tick), .i_fire_valid(fire_valid), .o_fire_ready(fire_ready),
        .i_fire_x(fire_x), .i_fire_y(fire_y), .i_kill_mask(kill_mask),
        .o_active_mask(active_mask), .o_data(data), .o_draw(draw)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pix(input int h, input int v);
        hcount = 10'(h);
        vcount = 10'(v);
        tick();
    endtask

    task automatic fire(input int x, input int y);
        fire_x = 10'(x);
        fire_y = 10'(y);
        fire_valid = 1'b1;
        tick();
        fire_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        fire_valid = 1'b0;
        frame_tick = 1'b0;
        kill_mask = '0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks += 4;
        if (active_mask !== 4'b0000) begin errors++; $display("FAIL reset_mask: got %b exp 0000", active_mask); end
        if (draw !== 1'b0) begin errors++; $display("FAIL reset_draw: got %b exp 0", draw); end
        if (data !== 6'b0) begin errors++; $display("FAIL reset_data: got %b exp 000000", data); end
        if (fire_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b exp 0", fire_ready); end
        tick();
        checks++;
        if (fire_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_after: got %b exp 1", fire_ready); end
    endtask

    task automatic test_single();
        int hs[6] = '{100, 107, 108, 100, 99, 103};
        int vs[6] = '{400, 410, 400, 411, 405, 399};
        logic ex[6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        fire_valid = 1'b1;
        #1;
        checks++;
        if (fire_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b exp 1", fire_ready); end
        fire(100, 400);
        checks++;
        if (active_mask !== 4'b0001) begin errors++; $display("FAIL single_mask: got %b exp 0001", active_mask); end
        for (int i = 0; i < 6; i++) begin
            pix(hs[i], vs[i]);
            checks += 2;
            if (draw !== ex[i]) begin errors++; $display("FAIL single_draw(%0d,%0d): got %b exp %b", hs[i], vs[i], draw, ex[i]); end
            if (data !== (ex[i] ? 6'b101010 : 6'b000000)) begin errors++; $display("FAIL single_data(%0d,%0d): got %b", hs[i], vs[i], data); end
        end
    endtask

    task automatic test_fill();
        logic [3:0] em[5] = '{4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1111};
        do_reset();
        tick();
        fire_valid = 1'b1;
        for (int k = 0; k < 5; k++) begin
            fire_x = 10'(20 * k);
            fire_y = 10'd50;
            tick();
            checks += 2;
            if (active_mask !== em[k]) begin errors++; $display("FAIL fill_mask[%0d]: got %b exp %b", k, active_mask, em[k]); end
            if (fire_ready !== (k < 3)) begin errors++; $display("FAIL fill_ready[%0d]: got %b exp %b", k, fire_ready, k < 3); end
        end
        fire_valid = 1'b0;
        pix(80, 50);
        checks++;
        if (draw !== 1'b0) begin errors++; $display("FAIL fill_ignored_draw: got %b exp 0", draw); end
    endtask

    task automatic test_move();
        int bot[5] = '{16, 12, 8, 4, 0};
        do_reset();
        tick();
        fire(200, 10);
        for (int n = 0; n < 5; n++) begin
            frame_tick = 1'b1;
            tick();
            frame_tick = 1'b0;
            checks++;
            if (active_mask !== 4'b0001) begin errors++; $display("FAIL move_mask[%0d]: got %b exp 0001", n, active_mask); end
            pix(200, bot[n]);
            checks++;
            if (draw !== 1'b1) begin errors++; $display("FAIL move_bottom[%0d]: got %b exp 1", n, draw); end
            pix(200, bot[n] + 1);
            checks++;
            if (draw !== 1'b0) begin errors++; $display("FAIL move_below[%0d]: got %b exp 0", n, draw); end
            if (n == 0) begin
                pix(200, 6);
                checks++;
                if (draw !== 1'b1) begin errors++; $display("FAIL move_top: got %b exp 1", draw); end
                pix(200, 5);
                checks++;
                if (draw !== 1'b0) begin errors++; $display("FAIL move_above: got %b exp 0", draw); end
            end
        end
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        checks++;
        if (active_mask !== 4'b0000) begin errors++; $display("FAIL move_retire: got %b exp 0000", active_mask); end
        pix(200, 0);
        checks++;
        if (draw !== 1'b0) begin errors++; $display("FAIL move_retire_draw: got %b exp 0", draw); end
    endtask

    task automatic test_simul();
        int hs[8] = '{0, 0, 60, 60, 20, 300, 300, 44};
        int vs[8] = '{96, 95, 106, 107, 96, 50, 49, 98};
        logic ex[8] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        do_reset();
        tick();
        for (int k = 0; k < 4; k++) fire(20 * k, 100);
        kill_mask = 4'b0100;
        frame_tick = 1'b1;
        fire_valid = 1'b1;
        fire_x = 10'd300;
        fire_y = 10'd50;
        #1;
        checks++;
        if (fire_ready !== 1'b0) begin errors++; $display("FAIL simul_ready_full: got %b exp 0", fire_ready); end
        tick();
        kill_mask = '0;
        frame_tick = 1'b0;
        checks += 2;
        if (active_mask !== 4'b1011) begin errors++; $display("FAIL simul_mask_kill: got %b exp 1011", active_mask); end
        if (fire_ready !== 1'b1) begin errors++; $display("FAIL simul_ready_free: got %b exp 1", fire_ready); end
        tick();
        fire_valid = 1'b0;
        checks++;
        if (active_mask !== 4'b1111) begin errors++; $display("FAIL simul_mask_refill: got %b exp 1111", active_mask); end
        for (int i = 0; i < 8; i++) begin
            pix(hs[i], vs[i]);
            checks++;
            if (draw !== ex[i]) begin errors++; $display("FAIL simul_draw(%0d,%0d): got %b exp %b", hs[i], vs[i], draw, ex[i]); end
        end
    endtask

    task automatic test_edge_x();
        int hs[4] = '{1023, 0, 1019, 1020};
        int vs[4] = '{0, 0, 0, 10};
        logic ex[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        do_reset();
        tick();
        fire(1020, 0);
        for (int i = 0; i < 4; i++) begin
            pix(hs[i], vs[i]);
            checks++;
            if (draw !== ex[i]) begin errors++; $display("FAIL edge_draw(%0d,%0d): got %b exp %b", hs[i], vs[i], draw, ex[i]); end
        end
    endtask

    task automatic test_reset_mid();
        fire(500, 200);
        hcount = 10'd500;
        vcount = 10'd200;
        reset = 1'b0;
        frame_tick = 1'b1;
        fire_valid = 1'b1;
        fire_x = 10'd10;
        fire_y = 10'd10;
        tick();
        checks += 3;
        if (active_mask !== 4'b0000) begin errors++; $display("FAIL mid_reset_mask: got %b exp 0000", active_mask); end
        if (draw !== 1'b0) begin errors++; $display("FAIL mid_reset_draw: got %b exp 0", draw); end
        if (data !== 6'b0) begin errors++; $display("FAIL mid_reset_data: got %b exp 000000", data); end
        reset = 1'b1;
        frame_tick = 1'b0;
        fire_valid = 1'b0;
        tick();
        pix(10, 10);
        checks += 2;
        if (active_mask !== 4'b0000) begin errors++; $display("FAIL mid_reset_noload: got %b exp 0000", active_mask); end
        if (draw !== 1'b0) begin errors++; $display("FAIL mid_reset_pix: got %b exp 0", draw); end
    endtask

`ifdef BULLET_COLOR_CYCLE_EN
    task automatic test_color();
        do_reset();
        tick();
        fire(100, 100);
        pix(100, 100);
        checks++;
        if (data !== 6'b101010) begin errors++; $display("FAIL color_phase0: got %b exp 101010", data); end
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        pix(100, 96);
        checks += 2;
        if (draw !== 1'b1) begin errors++; $display("FAIL color_draw: got %b exp 1", draw); end
        if (data !== 6'b111111) begin errors++; $display("FAIL color_phase1: got %b exp 111111", data); end
        frame_tick = 1'b1;
        tick();
        frame_tick = 1'b0;
        pix(100, 92);
        checks++;
        if (data !== 6'b101010) begin errors++; $display("FAIL color_phase2: got %b exp 101010", data); end
    endtask
`endif

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_move();
        test_simul();
        test_edge_x();
        test_reset_mid();
`ifdef BULLET_COLOR_CYCLE_EN
        test_color();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
